// File: rtl/program_loader.sv
// Boot-time loader: turns a byte stream into big-endian 32-bit instruction-memory writes
// and keeps the CPU in reset until the whole image has been written.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 256,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_W      = 17'(MAX_WORDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   count_q, count_d;
  logic [31:0]   word_q, word_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [15:0]   words_q, words_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   addr_q, addr_d;
  logic          ready_q, init_q, cpu_rst_q, busy_q, done_q, error_q;
  logic          accept;
  logic [15:0]   hdr_word;
  logic [31:0]   next_word;

  assign accept    = byte_valid & ready_q;
  assign hdr_word  = {count_q[15:8], byte_data};
  assign next_word = {word_q[23:0], byte_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    word_d  = word_q;
    idle_d  = idle_q;
    words_d = words_q;
    data_d  = data_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = 2'd0;
          idle_d  = '0;
          words_d = 16'd0;
        end
      end
      S_HDR: begin
        if (accept) begin
          idle_d = '0;
          if (cnt_q == 2'd0) begin
            count_d = {byte_data, 8'h00};
            cnt_d   = 2'd1;
          end else begin
            count_d = hdr_word;
            cnt_d   = 2'd0;
            if (hdr_word == 16'd0)
              state_d = S_DONE;
            else if ({1'b0, hdr_word} > MAX_W)
              state_d = S_ERROR;
            else
              state_d = S_LOAD;
          end
        end else if (idle_q == IDLE_LIMIT) begin
          state_d = S_ERROR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (accept) begin
          idle_d = '0;
          word_d = next_word;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            data_d  = next_word;
            addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
          end
        end else if (idle_q == IDLE_LIMIT) begin
          // Timeout drops whatever part of the word was collected.
          state_d = S_ERROR;
          cnt_d   = 2'd0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_WRITE: begin
        words_d = words_q + 16'd1;
        state_d = ((words_q + 16'd1) == count_q) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      count_q   <= 16'd0;
      word_q    <= 32'd0;
      idle_q    <= '0;
      words_q   <= 16'd0;
      data_q    <= 32'd0;
      addr_q    <= BASE_ADDR;
      ready_q   <= 1'b0;
      init_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      word_q    <= word_d;
      idle_q    <= idle_d;
      words_q   <= words_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      ready_q   <= (state_d == S_HDR) || (state_d == S_LOAD);
      init_q    <= (state_d == S_WRITE);
      cpu_rst_q <= (state_d != S_DONE);
      busy_q    <= (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_WRITE);
      done_q    <= (state_d == S_DONE);
      error_q   <= (state_d == S_ERROR);
    end
  end

  assign byte_ready                     = ready_q;
  assign initialize                     = init_q;
  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst                        = cpu_rst_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
  assign error                          = error_q;
  assign words_loaded                   = words_q;

endmodule
